// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, captures the memory word into IF/ID, and stops past the image end.
// One-edge fetch latency; a stall holds PC, IF/ID and the count, but an EX-stage branch overrides the stall.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MEM_BYTES = 132,
  parameter logic [31:0]       NOP       = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       instruction,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [31:0]       ifid_inst,
  output logic              ifid_valid,
  output logic              halted,
  output logic              error,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
    logic              valid;
  } ifid_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;

  // One extra bit so the end-of-image compare cannot wrap near the top of the address space.
  logic [ADDR_W:0] pc_plus4_wide;
  logic            past_end;
  logic            misaligned;

  assign pc_plus4_wide = {1'b0, pc_q} + (ADDR_W+1)'(4);
  assign past_end      = pc_plus4_wide > (ADDR_W+1)'(MEM_BYTES);
  assign misaligned    = branch_target[1:0] != 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= '{pc: '0, inst: NOP, valid: 1'b0};
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (branch_taken && misaligned) begin
          err_d        = 1'b1;
          state_d      = HALT;
          ifid_d.valid = 1'b0;
          ifid_d.inst  = NOP;
        end else if (branch_taken) begin
          pc_d         = branch_target;
          ifid_d.valid = 1'b0;
          ifid_d.inst  = NOP;
        end else if (stall) begin
          state_d = RUN;
        end else if (past_end) begin
          state_d      = HALT;
          ifid_d.valid = 1'b0;
          ifid_d.inst  = NOP;
        end else begin
          ifid_d = '{pc: pc_q, inst: instruction, valid: 1'b1};
          pc_d   = pc_plus4_wide[ADDR_W-1:0];
          if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
        end
      end
      HALT: begin
        // The instruction bus is never sampled here; out-of-range reads may be X.
        if (branch_taken && misaligned) begin
          err_d = 1'b1;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_addr   = pc_q;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_inst   = ifid_q.inst;
  assign ifid_valid  = ifid_q.valid;
  assign halted      = (state_q == HALT);
  assign error       = err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random stall/branch traffic against a reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] inst_addr;
  logic [31:0] instruction;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        halted;
  logic        error;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:32];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .inst_addr(inst_addr), .instruction(instruction),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
    .halted(halted), .error(error), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; anything past the image reads as X.
  always_comb begin
    instruction = 'x;
    if (inst_addr <= 64'd128 && inst_addr[1:0] == 2'b00) instruction = mem[inst_addr[7:2]];
  end

  // Reference model: what the fetch stage should be showing after each edge.
  bit          m_started;
  bit          m_halt;
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_inst;
  bit          m_vld;
  bit          m_err;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_started = 0; m_halt = 0; m_pc = 0; m_ipc = 0;
    m_inst = NOP; m_vld = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit s, input bit b, input logic [63:0] t);
    bit aligned;
    aligned = (t % 4) == 0;
    if (!m_started) begin
      m_started = 1;
    end else if (m_halt) begin
      if (b && !aligned) m_err = 1;
      else if (b) begin m_pc = t; m_halt = 0; end
    end else if (b && !aligned) begin
      m_err = 1; m_halt = 1; m_vld = 0; m_inst = NOP;
    end else if (b) begin
      m_pc = t; m_vld = 0; m_inst = NOP;
    end else if (s) begin
      m_vld = m_vld;
    end else if (m_pc > 64'd128) begin
      m_halt = 1; m_vld = 0; m_inst = NOP;
    end else begin
      m_inst = mem[m_pc / 4];
      m_ipc  = m_pc;
      m_vld  = 1;
      m_pc   = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("inst_addr",   inst_addr,         m_pc);
    check_eq("ifid_pc",     ifid_pc,           m_ipc);
    check_eq("ifid_inst",   {32'd0, ifid_inst}, {32'd0, m_inst});
    check_eq("ifid_valid",  {63'd0, ifid_valid}, {63'd0, m_vld});
    check_eq("halted",      {63'd0, halted},   {63'd0, m_halt});
    check_eq("error",       {63'd0, error},    {63'd0, m_err});
    check_eq("fetch_count", {32'd0, fetch_count}, {32'd0, m_cnt});
  endtask

  // Inputs change at the falling edge; outputs are compared on the next falling edge.
  task automatic cycle(input bit s, input bit b, input logic [63:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(s, b, t);
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] pc_before;
    reset = 1'b0; stall = 0; branch_taken = 0; branch_target = '0;
    for (int i = 0; i <= 32; i++) mem[i] = $urandom;
    mem[0] = 32'h00300293; mem[1] = 32'h00503223; mem[3] = 32'h00503623;
    mem[12] = 32'h04B90663; mem[32] = NOP;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Sequential fetch
    cycle(0, 0, 0);
    check_eq("idle_no_capture", {63'd0, ifid_valid}, 64'd0);
    cycle(0, 0, 0);
    check_eq("seq_inst0", {32'd0, ifid_inst}, 64'h00300293);
    check_eq("seq_pc0", ifid_pc, 64'd0);
    cycle(0, 0, 0);
    check_eq("seq_inst1", {32'd0, ifid_inst}, 64'h00503223);
    check_eq("seq_pc1", ifid_pc, 64'd4);
    check_eq("seq_count", {32'd0, fetch_count}, 64'd2);
    cycle(0, 0, 0);

    // Stall for three cycles at ifid_pc 8
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      check_eq("stall_ifid_pc", ifid_pc, 64'd8);
      check_eq("stall_addr", inst_addr, 64'd12);
      check_eq("stall_count", {32'd0, fetch_count}, 64'd3);
    end
    cycle(0, 0, 0);
    check_eq("unstall_pc", ifid_pc, 64'd12);
    check_eq("unstall_inst", {32'd0, ifid_inst}, 64'h00503623);

    // Branch overriding a stall
    cycle(1, 1, 64'd48);
    check_eq("br_bubble_vld", {63'd0, ifid_valid}, 64'd0);
    check_eq("br_bubble_inst", {32'd0, ifid_inst}, {32'd0, NOP});
    check_eq("br_addr", inst_addr, 64'd48);
    cycle(0, 0, 0);
    check_eq("br_tgt_pc", ifid_pc, 64'd48);
    check_eq("br_tgt_inst", {32'd0, ifid_inst}, 64'h04B90663);

    // Run to the end of the image
    for (int i = 0; i < 40 && m_ipc != 64'd128; i++) cycle(0, 0, 0);
    check_eq("end_pc", ifid_pc, 64'd128);
    check_eq("end_inst", {32'd0, ifid_inst}, {32'd0, NOP});
    cycle(0, 0, 0);
    check_eq("end_halted", {63'd0, halted}, 64'd1);
    check_eq("end_vld", {63'd0, ifid_valid}, 64'd0);
    check_eq("end_addr", inst_addr, 64'd132);
    repeat (3) cycle($urandom_range(0, 1), 0, 0);
    check_eq("halt_halted", {63'd0, halted}, 64'd1);
    cycle(0, 1, 64'd0);
    check_eq("restart_run", {63'd0, halted}, 64'd0);
    cycle(0, 0, 0);
    check_eq("restart_pc", ifid_pc, 64'd0);
    check_eq("restart_vld", {63'd0, ifid_valid}, 64'd1);

    // Misaligned target
    pc_before = m_pc;
    cycle(0, 1, 64'd6);
    check_eq("mis_error", {63'd0, error}, 64'd1);
    check_eq("mis_halted", {63'd0, halted}, 64'd1);
    check_eq("mis_addr", inst_addr, pc_before);
    cycle(0, 1, 64'd16);
    cycle(0, 0, 0);
    check_eq("mis_restart_pc", ifid_pc, 64'd16);
    check_eq("mis_sticky", {63'd0, error}, 64'd1);

    // Asynchronous reset at PC 40
    for (int i = 0; i < 20 && m_pc != 64'd40; i++) cycle(0, 0, 0);
    check_eq("pre_reset_addr", inst_addr, 64'd40);
    async_reset();
    check_eq("rst_error", {63'd0, error}, 64'd0);
    cycle(0, 0, 0);
    check_eq("rst_idle_vld", {63'd0, ifid_valid}, 64'd0);
    cycle(0, 0, 0);
    check_eq("rst_first_pc", ifid_pc, 64'd0);
    check_eq("rst_first_vld", {63'd0, ifid_valid}, 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit          s, b;
      logic [63:0] t;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 19))
        0:       t = 64'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
        1:       t = {$urandom, $urandom} & ~64'd3;
        default: t = 64'($urandom_range(0, 34) * 4);
      endcase
      cycle(s, b, t);
      if (i % 200 == 199) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the hazard-controlled RISC-V pipeline. It owns the program counter and drives the byte address into the combinational instruction memory. It captures the returned word into the IF/ID pipeline register. It applies hazard-unit stalls and EX-stage branch redirects, and stops fetching when the PC runs past the end of the loaded program image.

## Interface
Parameters:
- `ADDR_W`, 64, width of PC and instruction address
- `RESET_PC`, 64'd0, PC loaded on reset
- `MEM_BYTES`, 132, size of instruction memory in bytes; a word at `pc` is fetchable only when `pc + 4 <= MEM_BYTES`
- `NOP`, 32'h00000013, bubble word (`addi x0,x0,0`)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `branch_taken`  in  1  EX stage: redirect fetch this cycle
- `branch_target`  in  ADDR_W  redirect address
- `inst_addr`  out  ADDR_W  byte address to instruction memory (= PC register)
- `instruction`  in  32  word returned combinationally for `inst_addr`
- `ifid_pc`  out  ADDR_W  PC of the word held in IF/ID
- `ifid_inst`  out  32  instruction held in IF/ID
- `ifid_valid`  out  1  IF/ID holds a real fetched instruction
- `halted`  out  1  fetch stopped (state HALT)
- `error`  out  1  sticky: misaligned branch target seen
- `fetch_count`  out  32  number of words captured into IF/ID; saturates at 32'hFFFFFFFF

## Operation
- States: IDLE, RUN, HALT.
- **IDLE:** entered on reset. Lasts exactly one clock. At that edge the block moves to RUN with no capture and PC unchanged.
- **RUN:** actions at each edge, in priority order:
  1. `branch_taken` with `branch_target[1:0] != 0`: `error <= 1`; go to HALT; PC unchanged; `ifid_valid <= 0`; `ifid_inst <= NOP`.
  2. `branch_taken`, aligned target: `pc <= branch_target`; `ifid_valid <= 0`; `ifid_inst <= NOP`. The squashed ID instruction is dropped. This overrides `stall`.
  3. `stall`: PC, IF/ID and `fetch_count` all hold.
  4. `pc + 4 > MEM_BYTES`: go to HALT; `ifid_valid <= 0`; `ifid_inst <= NOP`; PC holds.
  5. Otherwise: `ifid_inst <= instruction`; `ifid_pc <= pc`; `ifid_valid <= 1`; `pc <= pc + 4`; `fetch_count` increments.
- **HALT:** `halted = 1`; `ifid_valid = 0`; `instruction` is ignored, including X from out-of-range reads.
  - An aligned `branch_taken` (an in-flight branch) sets `pc <= branch_target` and returns to RUN.
  - A misaligned `branch_taken` sets `error` and stays in HALT.
  - `stall` is ignored in HALT.
- A branch target that is out of range but aligned enters RUN, then halts on the next non-stalled edge via rule 4.
- PC arithmetic is modulo 2^ADDR_W. `pc + 4` is computed at ADDR_W+1 bits so that the range compare never wraps.
- `error` is cleared only by reset.

## Timing
- Reset values: `pc`/`inst_addr` = RESET_PC, state = IDLE, `ifid_pc` = 0, `ifid_inst` = NOP, `ifid_valid` = 0, `halted` = 0, `error` = 0, `fetch_count` = 0.
- Asserting reset mid-operation forces these values immediately, without waiting for a clock edge.
- `inst_addr` is a direct register output, with no combinational path from any input.
- Fetch latency: a word at PC appears on `ifid_inst` one edge after PC is presented.
- First valid IF/ID: at the 2nd rising edge after reset deassertion (IDLE edge, then capture edge).
- Branch penalty: `branch_taken` at edge N puts a bubble in IF/ID after edge N. The target word is valid after edge N+1.
- Stall held for k cycles delays every subsequent capture by exactly k edges; no word is lost or duplicated.
- `halted` rises on the edge of the HALT transition and falls on the edge of a redirect out of HALT.

## Test plan
- **Sequential fetch:** bubble-sort image loaded, release reset, no stall or branch. Required response:
  - After edge 2: `ifid_inst` = 32'h00300293, `ifid_pc` = 0.
  - After edge 3: `ifid_inst` = 32'h00503223, `ifid_pc` = 4.
  - `fetch_count` = 2.
- **Stall:** assert `stall` for 3 cycles while `ifid_pc` = 8. Required response: IF/ID, `inst_addr` = 12 and `fetch_count` all frozen. After release, the next edge gives `ifid_pc` = 12, `ifid_inst` = 32'h00503623.
- **Branch with simultaneous stall:** `branch_taken` = 1 and `stall` = 1, target 64'd48. Required response:
  - Next edge: `ifid_valid` = 0, `ifid_inst` = NOP, `inst_addr` = 48.
  - Following edge: `ifid_pc` = 48, `ifid_inst` = 32'h04B90663.
- **End of image:** run sequentially to PC 128. Required response:
  - Capture of 32'h00000013 with `ifid_pc` = 128.
  - Next edge: `halted` = 1, `ifid_valid` = 0, `inst_addr` = 132.
  - `fetch_count` stable thereafter.
  - Then `branch_taken` with target 0: RUN resumes and `ifid_pc` = 0 two edges later.
- **Misaligned target:** `branch_taken` with target 64'd6 in RUN. Required response: `error` = 1, `halted` = 1, PC unchanged. A later aligned branch restarts fetch while `error` stays 1.
- **Reset mid-run:** drop `reset` asynchronously between edges at PC 40. Required response: all outputs take their reset values before the next edge. After release, the first valid capture is again at PC 0, on edge 2.
